// File: rtl/dflow_merge_sink.sv
// Merges two unbackpressured data-flow streams into one first-word fall-through FIFO
// with a ready/valid sink side, carrying per-word taint and keeping taint/drop statistics.
module dflow_merge_sink #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in1_data,
  input  logic                       in1_valid,
  input  logic [DATA_W-1:0]          in1_data_t0,
  input  logic                       in1_valid_t0,
  input  logic [DATA_W-1:0]          in2_data,
  input  logic                       in2_valid,
  input  logic [DATA_W-1:0]          in2_data_t0,
  input  logic                       in2_valid_t0,
  output logic [DATA_W-1:0]          out_data,
  output logic [DATA_W-1:0]          out_data_t0,
  output logic                       out_src,
  output logic                       out_taint,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [CNT_W-1:0]           taint_cnt,
  output logic                       ctrl_taint
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] r_memData [DEPTH];
  logic [DATA_W-1:0] r_memDataT [DEPTH];
  logic              r_memSrc [DEPTH];
  logic              r_memVt [DEPTH];

  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [LW-1:0]    r_level;
  logic [CNT_W-1:0] r_dropCnt;
  logic [CNT_W-1:0] r_taintCnt;
  logic             r_ctrlTaint;

  logic             w_pop;
  logic [LW-1:0]    w_free;
  logic             w_push1;
  logic             w_push2;
  logic [1:0]       w_dropN;
  logic [PW-1:0]    w_wrPtr2;
  logic [CNT_W:0]   w_dropSum;

  // Head entry is read combinationally so a word is visible the cycle after its push.
  assign out_data    = r_memData[r_rdPtr];
  assign out_data_t0 = r_memDataT[r_rdPtr];
  assign out_src     = r_memSrc[r_rdPtr];
  assign out_taint   = (|r_memDataT[r_rdPtr]) | r_memVt[r_rdPtr];
  assign out_valid   = (r_level != '0);
  assign level       = r_level;
  assign drop_cnt    = r_dropCnt;
  assign taint_cnt   = r_taintCnt;
  assign ctrl_taint  = r_ctrlTaint;

  assign w_pop    = out_valid & out_ready;
  assign w_free   = LW'(DEPTH) - r_level + LW'(w_pop);
  assign w_push1  = !rst && in1_valid && (w_free != '0);
  assign w_push2  = !rst && in2_valid &&
                    (in1_valid ? (w_free >= LW'(2)) : (w_free != '0));
  assign w_dropN  = {1'b0, in1_valid & ~w_push1} + {1'b0, in2_valid & ~w_push2};
  assign w_wrPtr2 = r_wrPtr + PW'(w_push1);
  assign w_dropSum = {1'b0, r_dropCnt} + (CNT_W+1)'(w_dropN);

  // Storage has no reset; occupancy is tracked solely by the pointers and level.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push1 && (PW'(i) == r_wrPtr)) begin
        r_memData[i]  <= in1_data;
        r_memDataT[i] <= in1_data_t0;
        r_memSrc[i]   <= 1'b0;
        r_memVt[i]    <= in1_valid_t0;
      end else if (w_push2 && (PW'(i) == w_wrPtr2)) begin
        r_memData[i]  <= in2_data;
        r_memDataT[i] <= in2_data_t0;
        r_memSrc[i]   <= 1'b1;
        r_memVt[i]    <= in2_valid_t0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdPtr     <= '0;
      r_wrPtr     <= '0;
      r_level     <= '0;
      r_dropCnt   <= '0;
      r_taintCnt  <= '0;
      r_ctrlTaint <= 1'b0;
    end else begin
      r_rdPtr <= r_rdPtr + PW'(w_pop);
      r_wrPtr <= r_wrPtr + PW'(w_push1) + PW'(w_push2);
      r_level <= r_level + LW'(w_push1) + LW'(w_push2) - LW'(w_pop);
      // Both counters saturate at all-ones instead of wrapping.
      r_dropCnt <= w_dropSum[CNT_W] ? '1 : w_dropSum[CNT_W-1:0];
      if (w_pop && out_taint && (r_taintCnt != '1)) r_taintCnt <= r_taintCnt + 1'b1;
      if (in1_valid_t0 || in2_valid_t0) r_ctrlTaint <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dflow_merge_sink.sv
// Directed bench for dflow_merge_sink: reset, FWFT latency, merge order,
// overflow drops, control-taint stickiness and mid-traffic reset.
module tb_dflow_merge_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in1_data, in1_data_t0, in2_data, in2_data_t0;
  logic        in1_valid, in1_valid_t0, in2_valid, in2_valid_t0;
  logic [31:0] out_data, out_data_t0;
  logic        out_src, out_taint, out_valid, out_ready;
  logic [2:0]  level;
  logic [15:0] drop_cnt, taint_cnt;
  logic        ctrl_taint;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  dflow_merge_sink #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in1_data(in1_data), .in1_valid(in1_valid),
    .in1_data_t0(in1_data_t0), .in1_valid_t0(in1_valid_t0),
    .in2_data(in2_data), .in2_valid(in2_valid),
    .in2_data_t0(in2_data_t0), .in2_valid_t0(in2_valid_t0),
    .out_data(out_data), .out_data_t0(out_data_t0), .out_src(out_src),
    .out_taint(out_taint), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .drop_cnt(drop_cnt), .taint_cnt(taint_cnt),
    .ctrl_taint(ctrl_taint)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v1, input logic [31:0] d1, input logic [31:0] t1,
                               input logic vt1, input logic v2, input logic [31:0] d2,
                               input logic [31:0] t2, input logic vt2, input logic rdy);
    in1_valid = v1; in1_data = d1; in1_data_t0 = t1; in1_valid_t0 = vt1;
    in2_valid = v2; in2_data = d2; in2_data_t0 = t2; in2_valid_t0 = vt2;
    out_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rdy);
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [31:0] drainExp [4];

    rst = 1'b1;
    idle(1'b0);
    tick(); tick();
    rst = 1'b0;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("rst_taint", 32'(taint_cnt), 32'd0);
    checkOutput("rst_ctrl", 32'(ctrl_taint), 32'd0);

    // Single tainted word with the sink ready.
    applyStimulus(1'b1, 32'hdeadbeef, 32'hffffffff, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    idle(1'b1);
    checkOutput("t2_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_data", out_data, 32'hdeadbeef);
    checkOutput("t2_dataT", out_data_t0, 32'hffffffff);
    checkOutput("t2_taint", 32'(out_taint), 32'd1);
    checkOutput("t2_src", 32'(out_src), 32'd0);
    tick();
    checkOutput("t2_taintCnt", 32'(taint_cnt), 32'd1);
    checkOutput("t2_levelAfter", 32'(level), 32'd0);

    // Simultaneous push: in1 ahead of in2.
    applyStimulus(1'b1, 32'd1, 32'h0, 1'b0, 1'b1, 32'd2, 32'h0, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    checkOutput("t3_level", 32'(level), 32'd2);
    checkOutput("t3_head0", out_data, 32'd1);
    checkOutput("t3_src0", 32'(out_src), 32'd0);
    checkOutput("t3_taint0", 32'(out_taint), 32'd0);
    out_ready = 1'b1;
    tick();
    checkOutput("t3_head1", out_data, 32'd2);
    checkOutput("t3_src1", 32'(out_src), 32'd1);
    checkOutput("t3_level1", 32'(level), 32'd1);
    tick();
    checkOutput("t3_empty", 32'(out_valid), 32'd0);
    checkOutput("t3_taintCnt", 32'(taint_cnt), 32'd1);

    // Overflow: queue 3 words, then both valid with one free slot.
    applyStimulus(1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 32'h11, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h12, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("t4_level3", 32'(level), 32'd3);
    applyStimulus(1'b1, 32'hA, 32'h0, 1'b0, 1'b1, 32'hB, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("t4_levelFull", 32'(level), 32'd4);
    checkOutput("t4_drop1", 32'(drop_cnt), 32'd1);
    // Full but popping: the freed slot takes in1, in2 is dropped.
    applyStimulus(1'b1, 32'hC, 32'h0, 1'b0, 1'b1, 32'hD, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("t4_levelPop", 32'(level), 32'd4);
    checkOutput("t4_drop2", 32'(drop_cnt), 32'd2);
    applyStimulus(1'b1, 32'hE, 32'h0, 1'b0, 1'b1, 32'hF, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("t4_drop4", 32'(drop_cnt), 32'd4);
    checkOutput("t4_holdData", out_data, 32'h11);
    idle(1'b1);
    drainExp[0] = 32'h11; drainExp[1] = 32'h12; drainExp[2] = 32'hA; drainExp[3] = 32'hC;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t4_drain%0d", i), out_data, drainExp[i]);
      tick();
    end
    checkOutput("t4_drained", 32'(level), 32'd0);

    // Valid-taint without valid: sticky flag, no push.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h77, 32'h0, 1'b1, 1'b0);
    tick();
    idle(1'b0);
    checkOutput("t5_ctrl", 32'(ctrl_taint), 32'd1);
    checkOutput("t5_level", 32'(level), 32'd0);
    tick();
    checkOutput("t5_ctrlSticky", 32'(ctrl_taint), 32'd1);

    // Reset with traffic in flight.
    applyStimulus(1'b1, 32'h20, 32'h0, 1'b0, 1'b1, 32'h21, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h22, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h23, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("t6_level3", 32'(level), 32'd3);
    rst = 1'b1;
    applyStimulus(1'b1, 32'h99, 32'h0, 1'b1, 1'b1, 32'h98, 32'h0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    idle(1'b0);
    checkOutput("t6_level", 32'(level), 32'd0);
    checkOutput("t6_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_drop", 32'(drop_cnt), 32'd0);
    checkOutput("t6_taintCnt", 32'(taint_cnt), 32'd0);
    checkOutput("t6_ctrl", 32'(ctrl_taint), 32'd0);
    applyStimulus(1'b1, 32'h55, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    checkOutput("t6_newData", out_data, 32'h55);
    checkOutput("t6_newLevel", 32'(level), 32'd1);
    checkOutput("t6_newTaint", 32'(out_taint), 32'd0);

    // Stored valid-taint alone marks the word tainted and counts on pop.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h66, 32'h0, 1'b1, 1'b1);
    tick();
    idle(1'b1);
    checkOutput("t7_head", out_data, 32'h66);
    checkOutput("t7_taint", 32'(out_taint), 32'd1);
    checkOutput("t7_src", 32'(out_src), 32'd1);
    tick();
    checkOutput("t7_taintCnt", 32'(taint_cnt), 32'd1);
    checkOutput("t7_empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
